// File: rtl/spi_arb_pkg.sv
// Shared types and default widths for the SPI request arbiter.
package spi_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan requesters starting at ptr; the first hit wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found           = 1'b1;
        grant_idx       = cand;
        grant_oh[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI transaction port among NUM_REQ requesters, one transaction at a time.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_din,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_dout,
  output logic                      rsp_err,
  output logic                      spi_start,
  output logic                      spi_wr,
  output logic [ADDR_W-1:0]         spi_addr,
  output logic [DATA_W-1:0]         spi_din,
  input  logic [DATA_W-1:0]         spi_dout,
  input  logic                      spi_done,
  input  logic                      spi_err,
  output logic                      busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  arb_state_t         state, state_next;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   g_idx;
  logic [NUM_REQ-1:0] g_oh;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_REQ-1:0] grant_oh;
  logic [IDX_W-1:0]   grant_idx;
  logic               win_wr;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_din;
  logic [DATA_W-1:0]  rsp_dout_nx;
  logic               rsp_err_nx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (req),
    .ptr       (ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  // Select the winning requester's command fields.
  always_comb begin
    win_wr   = 1'b0;
    win_addr = '0;
    win_din  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        win_wr   = req_wr[i];
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_din  = req_din[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and response payload; done beats a same-cycle timeout.
  always_comb begin
    state_next  = state;
    rsp_dout_nx = '0;
    rsp_err_nx  = 1'b0;
    case (state)
      IDLE:  if (|req) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (spi_done) begin
          state_next  = RESP;
          rsp_dout_nx = spi_dout;
          rsp_err_nx  = spi_err;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_next = RESP;
          rsp_err_nx = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs, command latch, timeout counter and rr pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_dout  <= '0;
      rsp_err   <= 1'b0;
      spi_start <= 1'b0;
      spi_wr    <= 1'b0;
      spi_addr  <= '0;
      spi_din   <= '0;
      busy      <= 1'b0;
      ptr       <= '0;
      g_idx     <= '0;
      g_oh      <= '0;
      cnt       <= '0;
    end else begin
      spi_start <= (state_next == ISSUE);
      busy      <= (state_next != IDLE);
      rsp_valid <= (state_next == RESP) ? g_oh : '0;
      rsp_dout  <= rsp_dout_nx;
      rsp_err   <= rsp_err_nx;
      if (state == IDLE && |req) begin
        g_idx    <= grant_idx;
        g_oh     <= grant_oh;
        spi_wr   <= win_wr;
        spi_addr <= win_addr;
        spi_din  <= win_din;
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CNT_W'(1);
      if (state == RESP)
        ptr <= (g_idx == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx + IDX_W'(1);
    end
  end

endmodule
